// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters plus registered sync, blanking and end strobes.
// Optional completed-frame counter is built when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 11
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             end_of_line,
    output logic             end_of_frame,
    output logic [15:0]      frame_cnt
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must all be non-zero");
    end
    if (H_TOT > (1 << CNT_W) || V_TOT > (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOT/V_TOT");
    end

    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblnk;
    logic             r_vblnk;
    logic             r_eol;
    logic             r_eof;

    logic             w_h_last;
    logic             w_v_last;
    logic [CNT_W-1:0] w_hcount_nxt;
    logic [CNT_W-1:0] w_vcount_nxt;
    logic             w_hs_act;
    logic             w_vs_act;

    assign w_h_last = (r_hcount == H_LAST);
    assign w_v_last = (r_vcount == V_LAST);

    // NOTE: next-state values get a default before any branch, so no path leaves them unassigned (no latch).
    always_comb begin
        w_hcount_nxt = r_hcount + CNT_W'(1);
        w_vcount_nxt = r_vcount;
        if (w_h_last) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = w_v_last ? '0 : r_vcount + CNT_W'(1);
        end
    end

    // Strobes decode the next-state counters so they land on the same edge as the count they describe.
    assign w_hs_act = (w_hcount_nxt >= H_SYNC_BEG) && (w_hcount_nxt <= H_SYNC_END);
    assign w_vs_act = (w_vcount_nxt >= V_SYNC_BEG) && (w_vcount_nxt <= V_SYNC_END);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= ~HS_POL;
            r_vsync  <= ~VS_POL;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_eol    <= 1'b0;
            r_eof    <= 1'b0;
        end else if (en) begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_hsync  <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsync  <= w_vs_act ? VS_POL : ~VS_POL;
            r_hblnk  <= (w_hcount_nxt >= H_BLNK_BEG);
            r_vblnk  <= (w_vcount_nxt >= V_BLNK_BEG);
            r_eol    <= (w_hcount_nxt == H_LAST);
            r_eof    <= (w_hcount_nxt == H_LAST) && (w_vcount_nxt == V_LAST);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // end_of_frame is high on exactly the enabled edge that wraps to (0,0).
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (en && r_eof) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'h0000;
`endif

    assign hcount       = r_hcount;
    assign vcount       = r_vcount;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign hblnk        = r_hblnk;
    assign vblnk        = r_vblnk;
    assign end_of_line  = r_eol;
    assign end_of_frame = r_eof;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator: a single block holding the horizontal and vertical pixel counters plus every derived timing strobe (sync, blanking, line/frame end). It sits at the head of the video pipeline, driven by the pixel clock, and feeds the background, rectangle and character-rendering stages downstream. All timing is set by parameters, and a clock-enable lets it run at a divided pixel rate from a faster pclk.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- CNT_W, 11, counter width; must satisfy 2^CNT_W >= H_TOT and >= V_TOT
- pclk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  pixel-advance enable; counters and strobes update only when high
- hcount  out  CNT_W  horizontal position, 0..H_TOT-1
- vcount  out  CNT_W  vertical position, 0..V_TOT-1
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- hblnk  out  1  high while hcount >= H_ACTIVE
- vblnk  out  1  high while vcount >= V_ACTIVE
- end_of_line  out  1  high while hcount == H_TOT-1
- end_of_frame  out  1  high while hcount == H_TOT-1 and vcount == V_TOT-1
- frame_cnt  out  16  completed-frame count (see Configuration)

## Operation
- Derived constants: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOT likewise.
- hcount increments on each pclk edge with en=1. At H_TOT-1 it wraps to 0 and vcount advances. vcount wraps from V_TOT-1 to 0.
- The hsync active window is hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. The vsync active window is the same form on vcount.
- Every output is a register, computed from the next-state counter values, so each strobe is exactly coincident with the hcount/vcount it describes. There are no combinational outputs.
- With en=0, every register holds its value, including the strobes. A strobe asserted before a stall stays asserted through it.
- Reset has priority over en. Reset values: hcount=0, vcount=0, hsync=!HS_POL, vsync=!VS_POL, hblnk=0, vblnk=0, end_of_line=0, end_of_frame=0, frame_cnt=0.
- A reset asserted mid-frame returns the block to the reset state on the next edge. Counting resumes from (0,0) on the first en=1 edge after rst drops.
- There is no internal state machine beyond the counters. Region decode is a pure compare against the parameters.
- An elaboration-time check ($error) fires if any porch/sync parameter is 0 or if CNT_W is too narrow.

## Timing
- Latency: 0 cycles between the counter value and its strobes; both update on the same edge.
- First line: hblnk rises on the edge where hcount becomes H_ACTIVE (800 with defaults). hsync asserts at hcount 840 and deasserts at 968.
- end_of_line is high for exactly one enabled cycle per line, at hcount 1055 (defaults). end_of_frame is high for one enabled cycle per frame, at (1055, 627).
- A vertical strobe changes on the same edge as the hcount wrap 1055->0.

## Configuration
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: frame_cnt increments, wrapping at 2^16, on each enabled edge where end_of_frame is high, i.e. as the (0,0) wrap occurs.
- Undefined: no frame-counter register is built and frame_cnt is tied to 16'h0000. The port remains present in both cases.

## Test plan
- Reset then en=1 for 1056 cycles: hcount runs 0..1055 and wraps to 0, vcount goes 0->1, end_of_line is high only at hcount 1055, hblnk is high for hcount 800..1055, and hsync is high for hcount 840..967.
- Full frame at defaults (1056x628 cycles): vblnk is high for vcount 600..627, vsync is high for vcount 601..604, end_of_frame is a single pulse at (1055,627), and the next state is (0,0).
- en toggled 1/0 alternately: counters advance every second cycle, all strobes hold during en=0, and the frame takes 2x1056x628 cycles.
- rst asserted at (500,300) with en=1: the next edge gives hcount=0, vcount=0, hsync=vsync=0, hblnk=vblnk=0. Counting resumes from 0 after release.
- HS_POL=0, VS_POL=0 with small timing (H 8/2/2/2, V 4/1/1/1): hsync is low only at hcount 10..11, vsync is low only at vcount 5, and reset drives both syncs to 1.
- Build with VGA_TIMING_FRAME_CNT_EN and run 3 frames: frame_cnt reads 1, 2, 3 after each (0,0) wrap. Without the macro, frame_cnt stays 0 throughout.
